// File: rtl/led_pkg.sv
// Shared definitions for the LED output stage: config word field map,
// reset values and the PWM compare helper.
package led_pkg;

  // Config word field bounds (also the software-visible register map)
  localparam int DUTY_LSB = 0;
  localparam int DUTY_MSB = 7;
  localparam int MASK_LSB = 8;
  localparam int MASK_MSB = 23;
  localparam int EN_BIT   = 24;

  // Reset values of the config registers
  localparam logic [7:0]  DUTY_RST  = 8'hFF;
  localparam logic [15:0] MASK_RST  = 16'h0000;
  localparam logic        EN_RST    = 1'b1;

  // Blink starts in the lit half after reset
  localparam logic        PHASE_RST = 1'b1;

  // Full-scale duty forces the output permanently on
  localparam logic [7:0]  DUTY_FULL = 8'hFF;
  localparam logic [7:0]  PCNT_MAX  = 8'hFF;

  // PWM comparator: on while the counter is below the duty, or always at full scale
  function automatic logic pwm_on_f(input logic [7:0] pcnt, input logic [7:0] duty);
    return (duty == DUTY_FULL) || (pcnt < duty);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running time base: prescaler, 8-bit PWM counter and blink counter.
// Only Reset clears these counters; config writes never touch them.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int PWM_DIV       = 391,
  parameter int BLINK_PERIODS = 500
) (
  input  logic       CLK,
  input  logic       Reset,
  output logic [7:0] pcnt,
  output logic       wrap,
  output logic       phase
);

  localparam int PRE_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int BCNT_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(PWM_DIV - 1);
  localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(BLINK_PERIODS - 1);

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [7:0]        pcnt_q, pcnt_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              phase_q, phase_d;
  logic              tick;

  // Next-state logic for the prescaler, PWM counter and blink counter
  always_comb begin
    tick = (pre_q == PRE_MAX);
    wrap = tick && (pcnt_q == PCNT_MAX);

    if (tick) begin
      pre_d  = {PRE_W{1'b0}};
      pcnt_d = pcnt_q + 8'd1;
    end else begin
      pre_d  = pre_q + PRE_W'(1);
      pcnt_d = pcnt_q;
    end

    if (wrap) begin
      if (bcnt_q == BCNT_MAX) begin
        bcnt_d  = {BCNT_W{1'b0}};
        phase_d = ~phase_q;
      end else begin
        bcnt_d  = bcnt_q + BCNT_W'(1);
        phase_d = phase_q;
      end
    end else begin
      bcnt_d  = bcnt_q;
      phase_d = phase_q;
    end
  end

  // Counter state registers, cleared asynchronously by Reset
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pre_q   <= {PRE_W{1'b0}};
      pcnt_q  <= 8'h00;
      bcnt_q  <= {BCNT_W{1'b0}};
      phase_q <= PHASE_RST;
    end else begin
      pre_q   <= pre_d;
      pcnt_q  <= pcnt_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  assign pcnt  = pcnt_q;
  assign phase = phase_q;

endmodule

// File: rtl/led_pwm_stage.sv
// LED pin output stage: applies global enable, PWM dimming and a per-LED
// blink mask to the LED register value. Duty is double-buffered so a new
// value only takes effect at a PWM period boundary.
module led_pwm_stage
  import led_pkg::*;
#(
  parameter int PWM_DIV       = 391,
  parameter int BLINK_PERIODS = 500
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        WE,
  input  logic [31:0] WD,
  input  logic [15:0] LED_IN,
  output logic [15:0] LED_OUT
);

  logic [7:0]  pcnt;
  logic        wrap;
  logic        phase;

  logic [7:0]  duty_pend_q, duty_pend_d;
  logic [7:0]  duty_act_q,  duty_act_d;
  logic [15:0] mask_q,      mask_d;
  logic        en_q,        en_d;
  logic [15:0] led_out_q,   led_out_d;
  logic        pwm_on;

  // Reserved config bits are accepted and ignored
  logic        wd_rsvd_unused;
  assign wd_rsvd_unused = ^WD[31:25];

  led_tick_gen #(
    .PWM_DIV      (PWM_DIV),
    .BLINK_PERIODS(BLINK_PERIODS)
  ) u_tick_gen (
    .CLK  (CLK),
    .Reset(Reset),
    .pcnt (pcnt),
    .wrap (wrap),
    .phase(phase)
  );

  // Config capture, duty shadowing and output gating
  always_comb begin
    if (WE) begin
      duty_pend_d = WD[DUTY_MSB:DUTY_LSB];
      mask_d      = WD[MASK_MSB:MASK_LSB];
      en_d        = WD[EN_BIT];
    end else begin
      duty_pend_d = duty_pend_q;
      mask_d      = mask_q;
      en_d        = en_q;
    end

    // A write landing on the wrap cycle goes straight to the active duty
    if (wrap) begin
      if (WE) begin
        duty_act_d = WD[DUTY_MSB:DUTY_LSB];
      end else begin
        duty_act_d = duty_pend_q;
      end
    end else begin
      duty_act_d = duty_act_q;
    end

    pwm_on    = pwm_on_f(pcnt, duty_act_q);
    led_out_d = LED_IN & {16{en_q & pwm_on}} & (~mask_q | {16{phase}});
  end

  // Config and output registers, cleared asynchronously by Reset
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      duty_pend_q <= DUTY_RST;
      duty_act_q  <= DUTY_RST;
      mask_q      <= MASK_RST;
      en_q        <= EN_RST;
      led_out_q   <= 16'h0000;
    end else begin
      duty_pend_q <= duty_pend_d;
      duty_act_q  <= duty_act_d;
      mask_q      <= mask_d;
      en_q        <= en_d;
      led_out_q   <= led_out_d;
    end
  end

  assign LED_OUT = led_out_q;

endmodule

// File: tb/tb_led_pwm_stage.sv
// Directed bench for led_pwm_stage with a scoreboard queue of expected
// LED_OUT values, derived from cycle position since reset release.
module tb_led_pwm_stage;

  localparam int P_DIV  = 2;
  localparam int B_PER  = 2;
  localparam int PERIOD = 256 * P_DIV;
  localparam int HALF   = B_PER * PERIOD;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        WE;
  logic [31:0] WD;
  logic [15:0] LED_IN;
  logic [15:0] LED_OUT;

  led_pwm_stage #(.PWM_DIV(P_DIV), .BLINK_PERIODS(B_PER)) dut (
    .CLK    (CLK),
    .Reset  (Reset),
    .WE     (WE),
    .WD     (WD),
    .LED_IN (LED_IN),
    .LED_OUT(LED_OUT)
  );

  always #5 CLK = ~CLK;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          n        = 0;
  logic        m_en     = 1'b1;
  logic [15:0] m_mask   = 16'h0000;
  logic [7:0]  m_pend   = 8'hFF;
  logic [7:0]  m_act    = 8'hFF;
  logic [15:0] sb_q[$];

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h edge=%0d", tag, obs, exp, n);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, push expected output for the coming edge, sample at negedge
  task automatic step(input logic rst, input logic we, input logic [31:0] wd,
                      input logic [15:0] li, output logic [15:0] obs);
    logic [15:0] exp;
    logic [7:0]  pc;
    logic        ph;
    logic        on;
    Reset  = rst;
    WE     = we;
    WD     = wd;
    LED_IN = li;
    if (rst) begin
      exp    = 16'h0000;
      n      = 0;
      m_en   = 1'b1;
      m_mask = 16'h0000;
      m_pend = 8'hFF;
      m_act  = 8'hFF;
    end else begin
      pc  = 8'((n / P_DIV) % 256);
      ph  = ((n / HALF) % 2) == 0;
      on  = (m_act == 8'hFF) || (pc < m_act);
      exp = (m_en && on) ? (li & (~m_mask | {16{ph}})) : 16'h0000;
      if ((n % PERIOD) == PERIOD - 1) m_act = we ? wd[7:0] : m_pend;
      if (we) begin
        m_pend = wd[7:0];
        m_mask = wd[23:8];
        m_en   = wd[24];
      end
      n++;
    end
    sb_q.push_back(exp);
    @(posedge CLK);
    @(negedge CLK);
    obs = LED_OUT;
    if (sb_q.size() == 0) begin
      check_int("scoreboard_empty", 0, 1);
    end else begin
      exp = sb_q.pop_front();
      check16("led_out", obs, exp);
    end
  endtask

  initial begin
    logic [15:0] obs;
    int          on_cnt;

    // Reset held with all LEDs requested
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 16'hFFFF, obs);
    check16("reset_hold", obs, 16'h0000);

    // Pass-through with default config
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 32'h0, 16'hFFFF, obs);
    check16("pass_through", obs, 16'hFFFF);

    // Duty 0x40: 128 of every 512 cycles lit once the wrap has passed
    step(1'b0, 1'b1, 32'h0100_0040, 16'hA5A5, obs);
    for (int i = 0; i < PERIOD + 2 && (n % PERIOD) != 1; i++) step(1'b0, 1'b0, 32'h0, 16'hA5A5, obs);
    on_cnt = 0;
    for (int i = 0; i < PERIOD; i++) begin
      step(1'b0, 1'b0, 32'h0, 16'hA5A5, obs);
      if (obs === 16'hA5A5) on_cnt++;
    end
    check_int("duty40_on_cycles", on_cnt, 128);

    // Duty 0x10 written mid-period at pcnt 100: current period unchanged
    for (int i = 0; i < PERIOD + 2 && (n % PERIOD) != 200; i++) step(1'b0, 1'b0, 32'h0, 16'hA5A5, obs);
    step(1'b0, 1'b1, 32'h0100_0010, 16'hA5A5, obs);
    // Write on the wrap cycle itself applies to the period starting now
    for (int i = 0; i < PERIOD + 2 && (n % PERIOD) != PERIOD - 1; i++) step(1'b0, 1'b0, 32'h0, 16'hA5A5, obs);
    step(1'b0, 1'b1, 32'h0100_0020, 16'hA5A5, obs);
    on_cnt = 0;
    for (int i = 0; i < PERIOD; i++) begin
      step(1'b0, 1'b0, 32'h0, 16'hA5A5, obs);
      if (obs === 16'hA5A5) on_cnt++;
    end
    check_int("wrap_write_on_cycles", on_cnt, 64);

    // Blink mask on the low byte, full duty
    step(1'b0, 1'b1, 32'h0100_FFFF, 16'hFFFF, obs);
    for (int i = 0; i < 2 * HALF + 100; i++) step(1'b0, 1'b0, 32'h0, 16'hFFFF, obs);

    // Enable off then immediately back on
    step(1'b0, 1'b1, 32'h0000_00FF, 16'h3C3C, obs);
    step(1'b0, 1'b1, 32'h0100_00FF, 16'h3C3C, obs);
    check16("enable_off", obs, 16'h0000);
    step(1'b0, 1'b0, 32'h0, 16'h3C3C, obs);
    check16("enable_on", obs, 16'h3C3C);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 32'h0, 16'h3C3C, obs);

    // Mask + duty 0x40, run into the dark half, then reset asynchronously
    step(1'b0, 1'b1, 32'h0100_FF40, 16'hFFFF, obs);
    for (int i = 0; i < 3 * HALF && !(((n / HALF) % 2) == 1 && (n % PERIOD) == 10); i++)
      step(1'b0, 1'b0, 32'h0, 16'hFFFF, obs);
    check16("pre_reset_dark_half", obs, 16'hFF00);
    #2;
    Reset = 1'b1;
    #1;
    check16("async_reset", LED_OUT, 16'h0000);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 16'hFFFF, obs);

    // Defaults restored and blink phase restarts lit
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 16'hFFFF, obs);
    check16("post_reset_pass", obs, 16'hFFFF);
    step(1'b0, 1'b1, 32'h0100_FFFF, 16'hFFFF, obs);
    for (int i = 0; i < HALF + 100; i++) step(1'b0, 1'b0, 32'h0, 16'hFFFF, obs);
    check16("post_reset_dark_half", obs, 16'hFF00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
